regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  localparam int unsigned RF_DEF_WIDTH    = 64;
  localparam int unsigned RF_DEF_DEPTH    = 32;
  localparam int unsigned RF_DEF_ZERO_REG = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: decode issue sets, write-back clears, read ports look up.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = RF_DEF_DEPTH,
  parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = RF_DEF_ZERO_REG
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_en,
  input  logic                 i_set,
  input  logic [AW-1:0]        i_set_addr,
  input  logic [NWRITE-1:0]    i_clr,
  input  logic [NWRITE*AW-1:0] i_clr_addr,
  input  logic [NREAD*AW-1:0]  i_ra,
  output logic [NREAD-1:0]     o_busy_c
);

  localparam int unsigned NA = 1 << AW;
  // Addresses at or above DEPTH map to a 0 here and are ignored.
  localparam logic [NA-1:0] VALID_MASK = {NA{1'b1}} >> (NA - DEPTH);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW-1:0]    w_clr_a;
  logic [AW-1:0]    w_rd_a;

  // Clears first, then the set, so a same-cycle set on the same address wins.
  always_comb begin
    w_busy_nxt = r_busy;
    w_clr_a    = '0;
    if (i_en) begin
      for (int k = 0; k < int'(NWRITE); k++) begin
        w_clr_a = i_clr_addr[k*AW +: AW];
        if (i_clr[k] && VALID_MASK[w_clr_a]) begin
          w_busy_nxt[w_clr_a] = 1'b0;
        end
      end
      if (i_set && VALID_MASK[i_set_addr] && (i_set_addr != AW'(ZERO_REG))) begin
        w_busy_nxt[i_set_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_busy_c = '0;
    w_rd_a   = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      w_rd_a = i_ra[i*AW +: AW];
      if (VALID_MASK[w_rd_a]) begin
        o_busy_c[i] = r_busy[w_rd_a];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, hardwired zero register,
// self-initialisation to index values after reset, and a RAW hazard scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_DEF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEF_DEPTH,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = DEPTH - 1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*WIDTH-1:0]  rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*WIDTH-1:0] wd,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_addr,
  output logic                    ready
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned NA = 1 << AW;
  localparam logic [NA-1:0] VALID_MASK = {NA{1'b1}} >> (NA - DEPTH);

  rf_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_ready;
  logic [WIDTH-1:0]   r_regs [DEPTH];

  logic               w_run;
  logic [NREAD-1:0]   w_sb_busy;
  logic [AW-1:0]      w_ra;
  logic [AW-1:0]      w_wa;
  logic [WIDTH-1:0]   w_byp;
  logic               w_hit;

  assign w_run = (r_state == RF_RUN);
  assign ready = r_ready;

  // Init sequencer: one register per cycle, then park in RF_RUN with cnt held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_INIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DEPTH - 1)) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
          end
        end
        RF_RUN: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_state <= RF_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (r_state == RF_INIT) begin
      r_regs[r_cnt[AW-1:0]] <= (r_cnt == CW'(ZERO_REG)) ? '0 : WIDTH'(r_cnt);
    end else begin
      for (int k = 0; k < int'(NWRITE); k++) begin
        if (we[k] && VALID_MASK[wa[k*AW +: AW]] &&
            (wa[k*AW +: AW] != AW'(ZERO_REG))) begin
          r_regs[wa[k*AW +: AW]] <= wd[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_run),
    .i_set      (issue_valid),
    .i_set_addr (issue_addr),
    .i_clr      (we),
    .i_clr_addr (wa),
    .i_ra       (ra),
    .o_busy_c   (w_sb_busy)
  );

  // Read ports: later write ports override earlier ones in the bypass search.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    w_ra  = '0;
    w_wa  = '0;
    w_byp = '0;
    w_hit = 1'b0;
    for (int i = 0; i < int'(NREAD); i++) begin
      w_ra  = ra[i*AW +: AW];
      w_hit = 1'b0;
      w_byp = r_regs[w_ra];
      for (int k = 0; k < int'(NWRITE); k++) begin
        w_wa = wa[k*AW +: AW];
        if (we[k] && (w_wa == w_ra)) begin
          w_hit = 1'b1;
          w_byp = wd[k*WIDTH +: WIDTH];
        end
      end
      if (w_run && VALID_MASK[w_ra] && (w_ra != AW'(ZERO_REG))) begin
        rd[i*WIDTH +: WIDTH] = w_byp;
        rbusy[i]             = w_sb_busy[i] & ~w_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp in a 64x32, 2-read, 2-write configuration.
module tb_regfile_mp;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;
  localparam int unsigned AW = 5;

  logic              clk;
  logic              reset_n;
  logic [NR*AW-1:0]  ra;
  logic [NR*W-1:0]   rd;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*W-1:0]   wd;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              ready;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(
    .WIDTH    (W),
    .DEPTH    (D),
    .NREAD    (NR),
    .NWRITE   (NW),
    .ZERO_REG (31)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ra          (ra),
    .rd          (rd),
    .rbusy       (rbusy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic set_wr(input logic [NW-1:0] en,
                        input logic [AW-1:0] a0, input logic [63:0] d0,
                        input logic [AW-1:0] a1, input logic [63:0] d1);
    we = en;
    wa = {a1, a0};
    wd = {d1, d0};
  endtask

  task automatic set_issue(input logic v, input logic [AW-1:0] a);
    issue_valid = v;
    issue_addr  = a;
  endtask

  initial begin
    reset_n = 1'b0;
    ra = '0; we = '0; wa = '0; wd = '0;
    issue_valid = 1'b0; issue_addr = '0;

    // Reset state
    tick();
    set_ra(5'd5, 5'd30);
    settle();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd0",   rd[63:0],   64'd0);
    chk("rst_rbusy", 64'(rbusy), 64'd0);

    // Init sweep: ready must rise only after the 32nd edge; inputs are ignored meanwhile
    reset_n = 1'b1;
    set_wr(2'b01, 5'd5, 64'hBAD, 5'd0, 64'd0);
    set_issue(1'b1, 5'd30);
    for (int n = 1; n <= 32; n++) begin
      tick();
      if (n == 16) begin
        settle();
        chk("init_rd0",    rd[63:0],    64'd0);
        chk("init_rbusy",  64'(rbusy),  64'd0);
      end
      if (n == 31) chk("init_ready_lo", 64'(ready), 64'd0);
    end
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    set_issue(1'b0, 5'd0);
    settle();
    chk("init_ready_hi", 64'(ready),  64'd1);
    chk("init_r5",       rd[63:0],    64'd5);
    chk("init_r30",      rd[127:64],  64'd30);
    chk("init_rbusy0",   64'(rbusy),  64'd0);
    set_ra(5'd31, 5'd0);
    settle();
    chk("init_r31",      rd[63:0],    64'd0);
    chk("init_r0",       rd[127:64],  64'd0);

    // Bypass on write to r3
    set_ra(5'd3, 5'd3);
    set_wr(2'b01, 5'd3, 64'hDEAD, 5'd0, 64'd0);
    settle();
    chk("byp_same_rd0", rd[63:0],   64'hDEAD);
    chk("byp_same_rd1", rd[127:64], 64'hDEAD);
    tick();
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    settle();
    chk("byp_after_rd0", rd[63:0], 64'hDEAD);

    // Zero register ignores writes and issues
    set_ra(5'd31, 5'd31);
    set_wr(2'b01, 5'd31, 64'h1234, 5'd0, 64'd0);
    settle();
    chk("zero_byp_rd0", rd[63:0], 64'd0);
    tick();
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    set_issue(1'b1, 5'd31);
    settle();
    chk("zero_after_rd0", rd[63:0], 64'd0);
    tick();
    set_issue(1'b0, 5'd0);
    settle();
    chk("zero_rbusy", 64'(rbusy), 64'd0);

    // Two write ports on r7: port 1 wins
    set_ra(5'd7, 5'd6);
    set_wr(2'b11, 5'd7, 64'hA, 5'd7, 64'hB);
    settle();
    chk("mw_byp_rd0", rd[63:0],   64'hB);
    chk("mw_rd1",     rd[127:64], 64'd6);
    tick();
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    settle();
    chk("mw_after_rd0", rd[63:0], 64'hB);

    // Scoreboard: issue r9 and r12
    set_ra(5'd9, 5'd12);
    set_issue(1'b1, 5'd9);
    settle();
    chk("sb_issue_same", 64'(rbusy), 64'd0);
    tick();
    set_issue(1'b1, 5'd12);
    settle();
    chk("sb_r9_busy", 64'(rbusy), 64'b01);
    chk("sb_r9_rd",   rd[63:0],   64'd9);
    tick();
    set_issue(1'b0, 5'd0);
    settle();
    chk("sb_r12_busy", 64'(rbusy), 64'b11);

    // Writeback r9 with a same-cycle re-issue of r9: busy survives
    set_wr(2'b01, 5'd9, 64'h99, 5'd0, 64'd0);
    set_issue(1'b1, 5'd9);
    settle();
    chk("sb_setclr_byp", 64'(rbusy), 64'b10);
    chk("sb_setclr_rd",  rd[63:0],   64'h99);
    tick();
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    set_issue(1'b0, 5'd0);
    settle();
    chk("sb_setclr_after", 64'(rbusy), 64'b11);
    chk("sb_setclr_rd2",   rd[63:0],   64'h99);

    // Lone writeback of r9 on port 1
    set_wr(2'b10, 5'd0, 64'd0, 5'd9, 64'h77);
    settle();
    chk("sb_wb_same", 64'(rbusy), 64'b10);
    chk("sb_wb_rd",   rd[63:0],   64'h77);
    tick();
    set_wr(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    settle();
    chk("sb_wb_after",    64'(rbusy), 64'b10);
    chk("sb_wb_after_rd", rd[63:0],   64'h77);

    // Reset during operation, then again in the middle of init
    reset_n = 1'b0;
    settle();
    chk("midop_ready", 64'(ready), 64'd0);
    chk("midop_rbusy", 64'(rbusy), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 10; n++) tick();
    reset_n = 1'b0;
    settle();
    chk("midinit_ready", 64'(ready), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      if (n == 31) chk("reinit_ready_lo", 64'(ready), 64'd0);
    end
    settle();
    chk("reinit_ready_hi", 64'(ready),  64'd1);
    chk("reinit_rbusy",    64'(rbusy),  64'd0);
    chk("reinit_r9",       rd[63:0],    64'd9);
    chk("reinit_r12",      rd[127:64],  64'd12);
    set_ra(5'd3, 5'd7);
    settle();
    chk("reinit_r3", rd[63:0],   64'd3);
    chk("reinit_r7", rd[127:64], 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
